// File: rtl/ls_issue_queue.sv
// In-order load/store issue queue: holds memory ops until base (and store data)
// operands arrive on the CDB, then issues strictly from the head to the address unit.
module ls_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic             in_is_store,
  input  logic [2:0]       in_rob,
  input  logic             in_base_rdy,
  input  logic [31:0]      in_base_val,
  input  logic [2:0]       in_base_tag,
  input  logic             in_data_rdy,
  input  logic [31:0]      in_data_val,
  input  logic [2:0]       in_data_tag,
  input  logic [31:0]      in_imm,
  input  logic             cdb_valid,
  input  logic [2:0]       cdb_rob,
  input  logic [31:0]      cdb_value,
  output logic             issue_valid,
  output logic [31:0]      issue_value1,
  output logic [31:0]      issue_value2,
  output logic [4:0]       issue_op,
  output logic [2:0]       issue_rob,
  output logic [31:0]      issue_ls_value,
  output logic [PTR_W:0]   count
);

  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;

  logic [4:0]  r_op   [DEPTH];
  logic        r_st   [DEPTH];
  logic [2:0]  r_rob  [DEPTH];
  logic        r_brdy [DEPTH];
  logic [31:0] r_bval [DEPTH];
  logic [2:0]  r_btag [DEPTH];
  logic        r_drdy [DEPTH];
  logic [31:0] r_dval [DEPTH];
  logic [2:0]  r_dtag [DEPTH];
  logic [31:0] r_imm  [DEPTH];

  logic        r_iss_vld;
  logic [31:0] r_iss_v1, r_iss_v2, r_iss_ls;
  logic [4:0]  r_iss_op;
  logic [2:0]  r_iss_rob;

  logic [DEPTH-1:0] w_live;
  logic             w_acc, w_issue;
  logic             w_in_brdy, w_in_drdy;
  logic [31:0]      w_in_bval, w_in_dval;

  // An entry is live when its distance from head is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_live
    logic [PTR_W-1:0] w_off;
    assign w_off     = PTR_W'(g) - r_head;
    assign w_live[g] = {1'b0, w_off} < r_count;
  end

  assign in_ready = r_count < (PTR_W+1)'(DEPTH);
  assign w_acc    = in_valid && in_ready;
  assign w_issue  = (r_count != '0) && r_brdy[r_head] && (!r_st[r_head] || r_drdy[r_head]);

  // Operands produced on the CDB in the dispatch cycle are captured directly.
  assign w_in_brdy = in_base_rdy || (cdb_valid && cdb_rob == in_base_tag);
  assign w_in_bval = in_base_rdy ? in_base_val : cdb_value;
  assign w_in_drdy = in_data_rdy || (cdb_valid && cdb_rob == in_data_tag);
  assign w_in_dval = in_data_rdy ? in_data_val : cdb_value;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_iss_vld  <= 1'b0;
      r_iss_rob  <= '0;
      r_iss_v1   <= '0;
      r_iss_v2   <= '0;
      r_iss_op   <= '0;
      r_iss_ls   <= '0;
    end else begin
      if (w_acc)   r_tail <= r_tail + 1'b1;
      if (w_issue) r_head <= r_head + 1'b1;
      r_count   <= r_count + (PTR_W+1)'(w_acc) - (PTR_W+1)'(w_issue);
      r_iss_vld <= w_issue;
      r_iss_rob <= w_issue ? r_rob[r_head] : 3'd0;
      if (w_issue) begin
        r_iss_v1 <= r_bval[r_head];
        r_iss_v2 <= r_imm[r_head];
        r_iss_op <= r_op[r_head];
        r_iss_ls <= r_st[r_head] ? r_dval[r_head] : 32'd0;
      end
    end
  end

  // Entry payload needs no reset: liveness comes from head/count alone.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_acc && r_tail == PTR_W'(i)) begin
          r_op[i]   <= in_op;
          r_st[i]   <= in_is_store;
          r_rob[i]  <= in_rob;
          r_brdy[i] <= w_in_brdy;
          r_bval[i] <= w_in_bval;
          r_btag[i] <= in_base_tag;
          r_drdy[i] <= w_in_drdy;
          r_dval[i] <= w_in_dval;
          r_dtag[i] <= in_data_tag;
          r_imm[i]  <= in_imm;
        end else if (w_live[i] && cdb_valid) begin
          if (!r_brdy[i] && r_btag[i] == cdb_rob) begin
            r_brdy[i] <= 1'b1;
            r_bval[i] <= cdb_value;
          end
          if (!r_drdy[i] && r_dtag[i] == cdb_rob) begin
            r_drdy[i] <= 1'b1;
            r_dval[i] <= cdb_value;
          end
        end
      end
    end
  end

  assign count          = r_count;
  assign issue_valid    = r_iss_vld;
  assign issue_rob      = r_iss_rob;
  assign issue_value1   = r_iss_v1;
  assign issue_value2   = r_iss_v2;
  assign issue_op       = r_iss_op;
  assign issue_ls_value = r_iss_ls;

endmodule

// File: tb/tb_ls_issue_queue.sv
// Bench for ls_issue_queue: a queue-level reference model predicts issues,
// a negedge monitor compares DUT outputs against the scoreboard.
module tb_ls_issue_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, in_is_store, in_base_rdy, in_data_rdy, cdb_valid;
  logic [4:0]  in_op;
  logic [2:0]  in_rob, in_base_tag, in_data_tag, cdb_rob;
  logic [31:0] in_base_val, in_data_val, in_imm, cdb_value;
  logic        issue_valid;
  logic [31:0] issue_value1, issue_value2, issue_ls_value;
  logic [4:0]  issue_op;
  logic [2:0]  issue_rob;
  logic [PTR_W:0] count;

  ls_issue_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_is_store(in_is_store),
    .in_rob(in_rob), .in_base_rdy(in_base_rdy), .in_base_val(in_base_val),
    .in_base_tag(in_base_tag), .in_data_rdy(in_data_rdy), .in_data_val(in_data_val),
    .in_data_tag(in_data_tag), .in_imm(in_imm),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_value1(issue_value1), .issue_value2(issue_value2),
    .issue_op(issue_op), .issue_rob(issue_rob), .issue_ls_value(issue_ls_value),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    bit          st;
    logic [2:0]  rob;
    bit          brdy;
    logic [31:0] bval;
    logic [2:0]  btag;
    bit          drdy;
    logic [31:0] dval;
    logic [2:0]  dtag;
    logic [31:0] imm;
  } ent_t;

  typedef struct {
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  op;
    logic [2:0]  rob;
    logic [31:0] ls;
  } iss_t;

  ent_t mq[$];
  iss_t expq[$];
  iss_t last = '{default: '0};
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a program-order list of pending ops; the oldest issues
  // once its operands are known, results broadcast fill matching pending operands.
  ent_t ne;
  iss_t it;
  bit   acc;
  always @(posedge clk) begin
    if (rst || flush) begin
      mq.delete();
      last = '{default: '0};
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      if (mq.size() > 0 && mq[0].brdy && (!mq[0].st || mq[0].drdy)) begin
        ne = mq.pop_front();
        it = '{ne.bval, ne.imm, ne.op, ne.rob, ne.st ? ne.dval : 32'd0};
        expq.push_back(it);
        last = it;
      end
      if (cdb_valid) begin
        foreach (mq[k]) begin
          if (!mq[k].brdy && mq[k].btag == cdb_rob) begin mq[k].brdy = 1; mq[k].bval = cdb_value; end
          if (!mq[k].drdy && mq[k].dtag == cdb_rob) begin mq[k].drdy = 1; mq[k].dval = cdb_value; end
        end
      end
      if (acc) begin
        ne.op = in_op; ne.st = in_is_store; ne.rob = in_rob; ne.imm = in_imm;
        ne.btag = in_base_tag; ne.dtag = in_data_tag;
        ne.brdy = in_base_rdy || (cdb_valid && cdb_rob == in_base_tag);
        ne.bval = in_base_rdy ? in_base_val : cdb_value;
        ne.drdy = in_data_rdy || (cdb_valid && cdb_rob == in_data_tag);
        ne.dval = in_data_rdy ? in_data_val : cdb_value;
        mq.push_back(ne);
      end
    end
  end

  // Monitor: outputs are stable half a cycle after the active edge.
  iss_t got;
  always @(negedge clk) begin
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("issue_valid", 32'(issue_valid), 32'(expq.size() > 0));
    if (issue_valid) begin
      if (expq.size() > 0) begin
        got = expq.pop_front();
        chk("issue_rob", 32'(issue_rob), 32'(got.rob));
        chk("issue_value1", issue_value1, got.v1);
        chk("issue_value2", issue_value2, got.v2);
        chk("issue_op", 32'(issue_op), 32'(got.op));
        chk("issue_ls_value", issue_ls_value, got.ls);
      end
    end else begin
      expq.delete();
      chk("bubble_rob", 32'(issue_rob), 32'd0);
      chk("hold_value1", issue_value1, last.v1);
      chk("hold_value2", issue_value2, last.v2);
      chk("hold_op", 32'(issue_op), 32'(last.op));
      chk("hold_ls_value", issue_ls_value, last.ls);
    end
  end

  task automatic tick();
    @(negedge clk);
    rst = 0; flush = 0; in_valid = 0; cdb_valid = 0;
  endtask

  task automatic disp(input logic [4:0] op, input bit st, input logic [2:0] rob,
                      input bit br, input logic [31:0] bv, input logic [2:0] bt,
                      input bit dr, input logic [31:0] dv, input logic [2:0] dt,
                      input logic [31:0] imm);
    in_valid = 1; in_op = op; in_is_store = st; in_rob = rob;
    in_base_rdy = br; in_base_val = bv; in_base_tag = bt;
    in_data_rdy = dr; in_data_val = dv; in_data_tag = dt; in_imm = imm;
  endtask

  task automatic cdb(input logic [2:0] rob, input logic [31:0] val);
    cdb_valid = 1; cdb_rob = rob; cdb_value = val;
  endtask

  initial begin
    rst = 1; flush = 0; cdb_valid = 0;
    disp(5'h00, 0, 3'd1, 1, 32'h0, 3'd0, 0, 32'h0, 3'd0, 32'h0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; in_valid = 0;

    // ready load: issues one edge after dispatch
    disp(5'h03, 0, 3'd2, 1, 32'h1000, 3'd0, 0, 32'h0, 3'd0, 32'h10);
    tick(); tick(); tick();

    // store waiting on data from rob 1
    disp(5'h07, 1, 3'd3, 1, 32'h2000, 3'd0, 0, 32'h0, 3'd1, 32'h4);
    tick();
    cdb(3'd1, 32'hDEADBEEF);
    tick(); tick(); tick();

    // blocked head stalls a younger ready op
    disp(5'h01, 0, 3'd4, 0, 32'h0, 3'd5, 0, 32'h0, 3'd0, 32'h8);
    tick();
    disp(5'h02, 0, 3'd6, 1, 32'h3000, 3'd0, 0, 32'h0, 3'd0, 32'hC);
    tick(); tick(); tick();
    cdb(3'd5, 32'h5000);
    tick(); tick(); tick(); tick();

    // fill, drop a fifth, release, then wrap
    for (int i = 0; i < 5; i++) begin
      disp(5'(i), 0, 3'(i + 1), 0, 32'h0, 3'd7, 0, 32'h0, 3'd0, 32'(i * 4));
      tick();
    end
    cdb(3'd7, 32'h7000);
    tick();
    for (int i = 0; i < 4; i++) begin
      disp(5'(8 + i), i[0], 3'(i + 2), 1, 32'(32'hA000 + i), 3'd0, 1, 32'(32'hB000 + i), 3'd0, 32'(i));
      tick();
    end
    tick(); tick(); tick(); tick();

    // flush with dispatch and matching CDB in the same cycle
    for (int i = 0; i < 3; i++) begin
      disp(5'h04, 0, 3'(i + 1), 0, 32'h0, 3'd6, 0, 32'h0, 3'd0, 32'h0);
      tick();
    end
    flush = 1;
    cdb(3'd6, 32'h6666);
    disp(5'h05, 0, 3'd5, 1, 32'h5555, 3'd0, 0, 32'h0, 3'd0, 32'h1);
    tick(); tick(); tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) < 6)
        disp(5'($urandom), 1'($urandom), 3'($urandom_range(1, 7)),
             ($urandom_range(0, 1) == 1), $urandom, 3'($urandom_range(1, 7)),
             ($urandom_range(0, 1) == 1), $urandom, 3'($urandom_range(1, 7)), $urandom);
      if ($urandom_range(0, 1) == 1) cdb(3'($urandom_range(1, 7)), $urandom);
      tick();
    end
    // drain: every pending operand gets broadcast
    for (int c = 0; c < 40; c++) begin
      cdb(3'(c % 7 + 1), $urandom);
      tick();
    end
    tick(); tick();
    chk("drained", 32'(mq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ls_issue_queue.md
Name: ls_issue_queue

Overview:
- In-order load/store issue queue in front of the address unit.
- Holds dispatched memory ops until their base (and, for stores, data) operands arrive on the CDB.
- Issues the head entry to the address unit: value1 = base, value2 = immediate, plus op, ROB number and store data.
- Issue stays in program order, so address generation is never reordered.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >= 2).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  clock; all state changes on posedge
- rst  input  1  synchronous active-high reset
- flush  input  1  mispredict flush; clears the queue
- in_valid  input  1  dispatch request
- in_ready  output  1  queue can accept (count < DEPTH)
- in_op  input  5  memory op code (passed through)
- in_is_store  input  1  1 = store (needs data operand)
- in_rob  input  3  ROB number, nonzero
- in_base_rdy  input  1  base value is valid
- in_base_val  input  32  base value
- in_base_tag  input  3  producing ROB when not ready
- in_data_rdy  input  1  store data is valid (ignored for loads)
- in_data_val  input  32  store data
- in_data_tag  input  3  producing ROB for store data
- in_imm  input  32  sign-extended offset
- cdb_valid  input  1  result broadcast valid
- cdb_rob  input  3  broadcasting ROB number
- cdb_value  input  32  broadcast result
- issue_valid  output  1  issue outputs are live this cycle
- issue_value1  output  32  base to address unit
- issue_value2  output  32  immediate to address unit
- issue_op  output  5  op to address unit
- issue_rob  output  3  ROB number to address unit; 0 = bubble
- issue_ls_value  output  32  store data to address unit
- count  output  PTR_W+1  occupied entries

Behaviour:
- Storage: circular buffer with head, tail and count.
  - Per entry: op, is_store, rob, base_rdy/val/tag, data_rdy/val/tag, imm.
- Reset (rst=1 at posedge):
  - head = tail = count = 0; all entries invalid.
  - issue_valid = 0, issue_rob = 0; other issue outputs = 0.
  - rst overrides every other input.
- Flush (flush=1, rst=0):
  - Same clearing as reset.
  - Dispatch and CDB capture are ignored that cycle.
- Dispatch accept:
  - Accepted when in_valid && in_ready; entry written at tail; tail wraps modulo DEPTH.
  - in_ready is a function of registered count only.
  - Dispatch while full is dropped, with no state change.
- Dispatch bypass: if cdb_valid and cdb_rob equals a non-ready in_base_tag / in_data_tag in the accept cycle, the entry is written with cdb_value and marked ready.
- Wakeup: each posedge, every valid entry whose base (or data) is non-ready with tag == cdb_rob (and cdb_valid) captures cdb_value and sets rdy.
- Head ready condition: count > 0 && base_rdy && (!is_store || data_rdy), evaluated on registered state.
  - A CDB capture that lands at edge t makes the entry issuable only at edge t+1; no same-edge CDB-to-issue path.
- Issue (head ready):
  - Registered outputs at the posedge: issue_valid = 1, issue_value1 = base_val, issue_value2 = imm, issue_op, issue_rob, issue_ls_value.
  - issue_ls_value = data_val for stores, 0 for loads.
  - Head advances (wraps); count decrements.
- No issue: issue_valid = 0 and issue_rob = 0 (bubble). Other issue outputs hold their last values.
- Ordering: at most one issue per cycle, strictly from head. A non-ready head blocks younger ready entries.
- Simultaneous dispatch and issue: count is unchanged, and both pointers move.
  - Full + issue: in_ready was 0 that cycle, so no dispatch.
- Latency: dispatch with all operands ready into an empty queue at edge t -> issue outputs valid after edge t+1.
- Throughput: one issue per cycle when the head is ready every cycle.
- Entry reset values: all entry fields are don't-care when the entry is invalid.
  - Wakeup only affects valid entries (index within head..tail with count > 0).

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> count=0, issue_valid=0, issue_rob=0, in_ready=1.
- Ready load: dispatch in_op=5'h03, rob=2, base=0x1000, imm=0x10, rdy=1 at edge t -> after t+1: issue_valid=1, value1=0x1000, value2=0x10, rob=2, ls_value=0; next cycle issue_rob=0.
- Store wakeup: dispatch store rob=3, base rdy 0x2000, data tag=1 not ready; CDB rob=1 value=0xDEADBEEF at edge t -> issue at t+1 with ls_value=0xDEADBEEF.
- Head blocking: load rob=4 with base tag=5 pending, then ready load rob=6 -> nothing issues; CDB rob=5 -> rob 4 issues, then rob 6 the following cycle.
- Full / wrap: fill 4 ready-blocked entries -> in_ready=0, a 5th dispatch is dropped. Release all, then dispatch 4 more -> pointers wrap and order is preserved.
- Flush mid-operation: 3 entries queued, flush=1 with in_valid=1 and a matching CDB -> count=0, issue_rob=0, no entry written.
